// File: rtl/lcd_param_fmt.sv
// Serial double-dabble formatter: turns Kp/Ki/Kd and signed velocity into blank-padded ASCII
// fields for the LCD driver, committing all fields in a single edge.
module lcd_param_fmt #(
  parameter logic [31:0] VLABEL = "Vel "
) (
  input  logic        clk,
  input  logic        res,
  input  logic        go,
  input  logic [9:0]  kp,
  input  logic [9:0]  ki,
  input  logic [9:0]  kd,
  input  logic [10:0] vel,
  output logic [71:0] k_params,
  output logic [63:0] v_params,
  output logic        busy,
  output logic        upd
);

  typedef enum logic [1:0] {StIdle, StShift, StStore, StCommit} state_e;

  localparam logic [71:0] KReset = 72'h202030_202030_202030;
  localparam logic [31:0] VReset = 32'h20202030;

  state_e      state_q, state_d;
  logic [1:0]  vi_q, vi_d;
  logic [3:0]  sc_q, sc_d;
  logic [9:0]  ki_q, ki_d, kd_q, kd_d, vm_q, vm_d;
  logic        sign_q, sign_d;
  logic [11:0] bcd_q, bcd_d;
  logic [9:0]  bin_q, bin_d;
  logic [71:0] hold_k_q, hold_k_d, k_q, k_d;
  logic [31:0] hold_v_q, hold_v_d, v_q, v_d;
  logic        upd_q, upd_d;

  function automatic logic [9:0] sat999(input logic [10:0] x);
    return (x > 11'd999) ? 10'd999 : x[9:0];
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  logic [10:0] vabs;
  logic [11:0] adj;
  logic [3:0]  d2, d1, d0;
  logic [23:0] digits;
  logic [7:0]  sgn_chr;

  always_comb begin
    vabs = vel[10] ? (~vel + 11'd1) : vel;
    adj  = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    d2   = bcd_q[11:8];
    d1   = bcd_q[7:4];
    d0   = bcd_q[3:0];
    // Leading-zero blanking; units digit always printed.
    digits[23:16] = (d2 == 4'd0) ? 8'h20 : 8'h30 + {4'h0, d2};
    digits[15:8]  = (d2 == 4'd0 && d1 == 4'd0) ? 8'h20 : 8'h30 + {4'h0, d1};
    digits[7:0]   = 8'h30 + {4'h0, d0};
    sgn_chr       = (sign_q && vm_q != 10'd0) ? 8'h2d : 8'h20;
  end

  always_comb begin
    state_d  = state_q;
    vi_d     = vi_q;
    sc_d     = sc_q;
    ki_d     = ki_q;
    kd_d     = kd_q;
    vm_d     = vm_q;
    sign_d   = sign_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    hold_k_d = hold_k_q;
    hold_v_d = hold_v_q;
    k_d      = k_q;
    v_d      = v_q;
    upd_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          // Kp is loaded straight into the shifter; the rest wait in snapshot registers.
          bin_d   = sat999({1'b0, kp});
          ki_d    = sat999({1'b0, ki});
          kd_d    = sat999({1'b0, kd});
          vm_d    = sat999(vabs);
          sign_d  = vel[10];
          bcd_d   = 12'd0;
          vi_d    = 2'd0;
          sc_d    = 4'd0;
          state_d = StShift;
        end
      end
      StShift: begin
        bcd_d = {adj[10:0], bin_q[9]};
        bin_d = {bin_q[8:0], 1'b0};
        if (sc_q == 4'd9) begin
          state_d = StStore;
        end else begin
          sc_d = sc_q + 4'd1;
        end
      end
      StStore: begin
        unique case (vi_q)
          2'd0: hold_k_d[71:48] = digits;
          2'd1: hold_k_d[47:24] = digits;
          2'd2: hold_k_d[23:0]  = digits;
          2'd3: hold_v_d        = {sgn_chr, digits};
        endcase
        if (vi_q == 2'd3) begin
          state_d = StCommit;
        end else begin
          vi_d    = vi_q + 2'd1;
          bcd_d   = 12'd0;
          sc_d    = 4'd0;
          bin_d   = (vi_q == 2'd0) ? ki_q : (vi_q == 2'd1) ? kd_q : vm_q;
          state_d = StShift;
        end
      end
      StCommit: begin
        k_d     = hold_k_q;
        v_d     = hold_v_q;
        upd_d   = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q  <= StIdle;
      vi_q     <= 2'd0;
      sc_q     <= 4'd0;
      ki_q     <= 10'd0;
      kd_q     <= 10'd0;
      vm_q     <= 10'd0;
      sign_q   <= 1'b0;
      bcd_q    <= 12'd0;
      bin_q    <= 10'd0;
      hold_k_q <= KReset;
      hold_v_q <= VReset;
      k_q      <= KReset;
      v_q      <= VReset;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vi_q     <= vi_d;
      sc_q     <= sc_d;
      ki_q     <= ki_d;
      kd_q     <= kd_d;
      vm_q     <= vm_d;
      sign_q   <= sign_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      hold_k_q <= hold_k_d;
      hold_v_q <= hold_v_d;
      k_q      <= k_d;
      v_q      <= v_d;
      upd_q    <= upd_d;
    end
  end

  assign k_params = k_q;
  assign v_params = {VLABEL, v_q};
  assign busy     = (state_q != StIdle);
  assign upd      = upd_q;

endmodule

// File: tb/tb_lcd_param_fmt.sv
// Scoreboard bench for lcd_param_fmt: directed vectors push expected strings, a monitor
// pops and compares on every upd pulse.
module tb_lcd_param_fmt;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        go = 1'b0;
  logic [9:0]  kp = '0, ki = '0, kd = '0;
  logic [10:0] vel = '0;
  logic [71:0] k_params;
  logic [63:0] v_params;
  logic        busy, upd;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [71:0] k;
    logic [63:0] v;
  } exp_t;
  exp_t q[$];

  lcd_param_fmt dut (
    .clk      (clk),
    .res      (res),
    .go       (go),
    .kp       (kp),
    .ki       (ki),
    .kd       (kd),
    .vel      (vel),
    .k_params (k_params),
    .v_params (v_params),
    .busy     (busy),
    .upd      (upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every upd pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (upd) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_upd: got upd=1 expected no pulse at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("k_params", k_params, e.k);
        chk("v_params", {8'h0, v_params}, {8'h0, e.v});
      end
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [9:0] p, input logic [9:0] i, input logic [9:0] d,
                       input logic [10:0] v);
    kp = p; ki = i; kd = d; vel = v; go = 1'b1;
    @(posedge clk);  // edge 0
    #1 go = 1'b0;
  endtask

  task automatic run(input logic [9:0] p, input logic [9:0] i, input logic [9:0] d,
                     input logic [10:0] v, input logic [71:0] ek, input logic [63:0] ev);
    exp_t e;
    e.k = ek;
    e.v = ev;
    q.push_back(e);
    start(p, i, d, v);
    chk("busy_after_go", {71'h0, busy}, 72'h1);
    edges(44);
    chk("upd_before_commit", {71'h0, upd}, 72'h0);
    edges(1);
    chk("upd_at_edge45", {71'h0, upd}, 72'h1);
    chk("busy_after_commit", {71'h0, busy}, 72'h0);
    edges(1);
    chk("upd_one_cycle", {71'h0, upd}, 72'h0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_k", k_params, "  0  0  0");
    chk("rst_v", {8'h0, v_params}, {8'h0, 64'("Vel    0")});
    chk("rst_upd", {71'h0, upd}, 72'h0);
    chk("rst_busy", {71'h0, busy}, 72'h0);
  endtask

  initial begin
    exp_t e;
    #12;
    chk_reset_vals();
    res = 1'b1;
    edges(2);

    // Reset mid-run, then release.
    start(10'd77, 10'd1, 10'd2, 11'd3);
    edges(10);
    res = 1'b0;
    #1;
    chk_reset_vals();
    #20 res = 1'b1;
    edges(2);

    run(10'd123, 10'd45, 10'd7, -11'sd56, "123 45  7", "Vel - 56");
    run(10'd1023, 10'd1000, 10'd999, -11'sd1024, "999999999", "Vel -999");
    run(10'd1023, 10'd1000, 10'd999, 11'd1023, "999999999", "Vel  999");
    run(10'd0, 10'd100, 10'd10, 11'd0, "  0100 10", "Vel    0");
    run(10'd0, 10'd100, 10'd10, -11'sd1, "  0100 10", "Vel -  1");

    // Back-to-back with go held; kp changes mid-conversion.
    e.k = "  5  0  0"; e.v = "Vel    0"; q.push_back(e);
    e.k = "600  0  0"; e.v = "Vel    0"; q.push_back(e);
    kp = 10'd5; ki = 10'd0; kd = 10'd0; vel = 11'd0; go = 1'b1;
    edges(1);  // edge 0
    edges(20);
    kp = 10'd600;
    edges(25);  // edge 45
    chk("b2b_upd1", {71'h0, upd}, 72'h1);
    chk("b2b_k1", k_params, "  5  0  0");
    edges(1);  // edge 46: second conversion starts
    go = 1'b0;
    edges(44);  // edge 90
    chk("b2b_upd_gap", {71'h0, upd}, 72'h0);
    edges(1);  // edge 91
    chk("b2b_upd2", {71'h0, upd}, 72'h1);
    chk("b2b_k2", k_params, "600  0  0");
    edges(1);

    // Reset at edge 20 discards the conversion.
    start(10'd321, 10'd0, 10'd0, 11'd0);
    edges(20);
    res = 1'b0;
    #1;
    chk_reset_vals();
    #20 res = 1'b1;
    edges(60);
    chk("no_upd_after_abort_k", k_params, "  0  0  0");
    chk("no_upd_after_abort_busy", {71'h0, busy}, 72'h0);
    run(10'd321, 10'd0, 10'd0, 11'd0, "321  0  0", "Vel    0");

    edges(3);
    chk("scoreboard_empty", 72'(q.size()), 72'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_param_fmt.md
# lcd_param_fmt

Formatter stage directly upstream of the LCD driver: converts the binary PID gains and signed command velocity into the fixed-width ASCII fields the driver consumes. Its `k_params` and `v_params` outputs wire straight to the driver's inputs of the same names. Conversion is serial, using double-dabble with 10 shifts per value and four values in sequence. New strings are committed atomically, so the driver never sees a half-updated field.

## Interface
- `VLABEL`, default `"Vel "` (32-bit ASCII): constant placed in `v_params[63:32]`; this is the line-1 label.
- `clk` input 1: 50 MHz system clock; all state is updated on the rising edge.
- `res` input 1: reset, asynchronous and active-low.
- `go` input 1: conversion request, sampled only in IDLE and level-sensitive.
- `kp` input 10: unsigned Kp, 0..1023.
- `ki` input 10: unsigned Ki.
- `kd` input 10: unsigned Kd.
- `vel` input 11: signed two's-complement command velocity.
- `k_params` output 72: nine ASCII characters, `{Kp[3], Ki[3], Kd[3]}`; Kp occupies [71:48].
- `v_params` output 64: `{VLABEL, sign, d2, d1, d0}`.
- `busy` output 1: high whenever the state is not IDLE.
- `upd` output 1: one-cycle pulse in the first cycle that new strings are visible.

## Operation
- States are IDLE, SHIFT, STORE and COMMIT, with a value index `vi` of 0..3 (0=kp, 1=ki, 2=kd, 3=vel) and a shift counter `sc` of 0..9.
- **IDLE, go=1:**
  - Snapshot all inputs, with saturation applied.
  - Gains above 999 become 999.
  - The velocity sign is captured as `vel<0`. Its magnitude is |vel|, saturated to 999, so -1024..-1000 become 999 and 1000..1023 become 999.
  - Then set vi=0, sc=0 and go to SHIFT.
- **SHIFT:**
  - Each BCD nibble that is 5 or more gets +3.
  - Then shift {BCD[11:0], bin[9:0]} left by 1. The binary MSB is taken first.
  - After the shift with sc=9, go to STORE. Otherwise increment sc.
- **STORE:**
  - Convert the 3 BCD digits to ASCII (`8'h30 + d`) into a holding buffer, applying leading-zero blanking.
  - The hundreds digit becomes a space if it is 0. The tens digit becomes a space if both hundreds and tens are 0. The units digit is always printed.
  - For vi=3, the sign character is `"-"` if the sign is set and magnitude ≠ 0, otherwise `" "`. The sign always sits in the fixed leftmost position.
  - If vi<3: increment vi, clear BCD, load the next snapshot value, set sc=0 and go to SHIFT. If vi=3: go to COMMIT.
- **COMMIT:**
  - Copy the holding buffer to `k_params`/`v_params` in the same edge. `VLABEL` never changes.
  - Pulse `upd` and go to IDLE.
- `go` or input changes while busy are ignored; the snapshot governs the whole conversion.
- Reset (async, any state):
  - state=IDLE, vi=0, sc=0, upd=0, busy=0.
  - `k_params`=`"  0  0  0"`.
  - `v_params`={VLABEL,`"   0"`}.
  - Holding buffer is cleared to the same values.
- Reset mid-conversion discards the partial result. Outputs show reset values and no `upd` is issued.

## Timing
- Count clock edges from edge 0, the IDLE edge at which go=1 is sampled.
  - Edges 1–10: shifts for vi=0; edge 11: STORE.
  - Per value: 11 edges, so vi=k stores at edge 11(k+1).
  - Edge 44: vel STORE, then go to COMMIT.
  - Edge 45: outputs update and `upd` rises.
  - Edge 46: `upd` falls and state is IDLE; `go` is sampled again here.
- With go held high, conversions run back-to-back: outputs update every 46 cycles.
- `busy` is high from after edge 0 through the cycle following edge 45's COMMIT→IDLE transition (low after edge 45).
- Outputs are registered and are stable between commits.
- The LCD driver retriggers externally; the top level may use `upd` to pulse the driver's reset.

## Test plan
- **Reset:** assert res=0 mid-run, then release.
  - Required: `k_params`=`"  0  0  0"`, `v_params`=`"Vel    0"`, upd=0, busy=0.
- **Nominal:** kp=123, ki=45, kd=7, vel=-56, pulse go.
  - At edge 45: `k_params`=`"123 45  7"`, `v_params`=`"Vel - 56"`, upd high for exactly 1 cycle.
- **Saturation and sign:** kp=1023, ki=1000, kd=999, vel=-1024.
  - Required: `k_params`=`"999999999"`, `v_params`=`"Vel -999"`.
  - Repeat with vel=1023: required `"Vel  999"`.
- **Zero and boundaries:** kp=0, ki=100, kd=10, vel=0.
  - Required: `"  0100 10"`, `"Vel    0"`.
  - Repeat with vel=-1: required `"Vel -  1"`.
- **Snapshot and back-to-back:** hold go=1; change kp from 5 to 600 at edge 20.
  - First commit (edge 45) shows `"  5"`.
  - Second commit (edge 91) shows `"600"`.
  - upd pulses are 46 cycles apart.
- **Reset mid-operation:** pulse go with kp=321, then assert res at edge 20 and release.
  - Required: outputs remain at reset values and no upd pulse.
  - A subsequent go completes normally, 45 edges later.
